// File: rtl/wb_stage.sv
// Writeback stage: retires ALU results and formatted load data into the regfile write port.
// Optional WB_RETIRE_CNT_EN adds a 64-bit retired-op counter output (retire_cnt).
module wb_stage #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rd_addr,
  input  logic              in_wb_en,
  input  logic              in_is_load,
  input  logic [2:0]        in_funct3,
  input  logic [1:0]        in_offset,
  input  logic [DATA_W-1:0] in_result,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              write_en,
  output logic              err
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]       retire_cnt
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic {IDLE = 1'b0, WAIT_MEM = 1'b1} state_t;

  state_t              state_r, state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [ADDR_W-1:0]   ld_addr_r;
  logic                ld_wb_en_r;
  logic [2:0]          ld_funct3_r;
  logic [1:0]          ld_offset_r;
  logic                latch_s;
  logic                wr_s;
  logic                err_s;
  logic                retire_s;
  logic [ADDR_W-1:0]   rd_addr_s;
  logic [DATA_W-1:0]   rd_data_s;
  logic                accept_s;

  function automatic logic load_legal(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000, 3'b100: load_legal = 1'b1;
      3'b001, 3'b101: load_legal = (off != 2'd3);
      3'b010:         load_legal = (off == 2'd0);
      default:        load_legal = 1'b0;
    endcase
  endfunction

  // Lane select is a right shift by the byte offset, then extend per load type.
  function automatic logic [DATA_W-1:0] load_format(input logic [2:0] f3, input logic [1:0] off,
                                                    input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] sh;
    logic [7:0]        b;
    logic [15:0]       h;
    sh = w >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (f3)
      3'b000:  load_format = {{(DATA_W-8){b[7]}}, b};
      3'b001:  load_format = {{(DATA_W-16){h[15]}}, h};
      3'b100:  load_format = {{(DATA_W-8){1'b0}}, b};
      3'b101:  load_format = {{(DATA_W-16){1'b0}}, h};
      default: load_format = w;
    endcase
  endfunction

  assign in_ready = (state_r == IDLE);
  assign accept_s = in_valid && in_ready;

  // Next-state and next-output logic.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    latch_s   = 1'b0;
    wr_s      = 1'b0;
    err_s     = 1'b0;
    retire_s  = 1'b0;
    rd_addr_s = rd_addr;
    rd_data_s = rd_data;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (!in_is_load) begin
            wr_s      = in_wb_en && (|in_rd_addr);
            rd_addr_s = in_rd_addr;
            rd_data_s = in_result;
            retire_s  = 1'b1;
          end else if (load_legal(in_funct3, in_offset)) begin
            latch_s = 1'b1;
            cnt_s   = '0;
            state_s = WAIT_MEM;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT_MEM: begin
        // A response on the final wait cycle still completes normally.
        if (dmem_rvalid) begin
          wr_s      = ld_wb_en_r && (|ld_addr_r);
          rd_addr_s = ld_addr_r;
          rd_data_s = load_format(ld_funct3_r, ld_offset_r, dmem_rdata);
          retire_s  = 1'b1;
          cnt_s     = '0;
          state_s   = IDLE;
        end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
          err_s   = 1'b1;
          cnt_s   = '0;
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // State, load context and registered regfile outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      ld_addr_r   <= '0;
      ld_wb_en_r  <= 1'b0;
      ld_funct3_r <= 3'b000;
      ld_offset_r <= 2'b00;
      rd_addr     <= '0;
      rd_data     <= '0;
      write_en    <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      rd_addr  <= rd_addr_s;
      rd_data  <= rd_data_s;
      write_en <= wr_s;
      err      <= err_s;
      if (latch_s) begin
        ld_addr_r   <= in_rd_addr;
        ld_wb_en_r  <= in_wb_en;
        ld_funct3_r <= in_funct3;
        ld_offset_r <= in_offset;
      end
    end
  end

`ifdef WB_RETIRE_CNT_EN
  // Retired-op counter; wraps naturally at 2^64.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retire_cnt <= 64'd0;
    end else if (retire_s) begin
      retire_cnt <= retire_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expected writes/errors are queued at drive time, popped on output pulses.
module tb_wb_stage;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rd_addr = 5'd0;
  logic        in_wb_en = 1'b0;
  logic        in_is_load = 1'b0;
  logic [2:0]  in_funct3 = 3'd0;
  logic [1:0]  in_offset = 2'd0;
  logic [31:0] in_result = 32'd0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        write_en;
  logic        err;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt;
`endif

  typedef struct packed {
    logic        we;
    logic        er;
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_bad = 0;
  logic [63:0] m_retire = 64'd0;

  wb_stage #(.DATA_W(32), .ADDR_W(5), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd_addr(in_rd_addr), .in_wb_en(in_wb_en), .in_is_load(in_is_load),
    .in_funct3(in_funct3), .in_offset(in_offset), .in_result(in_result),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .rd_addr(rd_addr), .rd_data(rd_data), .write_en(write_en), .err(err)
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_legal(input logic [2:0] f3, input logic [1:0] off);
    if (f3 == 3'b000 || f3 == 3'b100) return 1'b1;
    if (f3 == 3'b001 || f3 == 3'b101) return off != 2'd3;
    if (f3 == 3'b010) return off == 2'd0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_fmt(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    begin b = w[7:0];   h = w[15:0];  end
      2'd1:    begin b = w[15:8];  h = w[23:8];  end
      2'd2:    begin b = w[23:16]; h = w[31:16]; end
      default: begin b = w[31:24]; h = 16'h0000; end
    endcase
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  // Every write or error pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (write_en === 1'b1 || err === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_pulse", {62'd0, write_en, err}, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("write_en", {63'd0, write_en}, {63'd0, e.we});
        check_eq("err", {63'd0, err}, {63'd0, e.er});
        if (e.we) begin
          check_eq("rd_addr", {59'd0, rd_addr}, {59'd0, e.a});
          check_eq("rd_data", {32'd0, rd_data}, {32'd0, e.d});
        end
      end
    end
  end

  task automatic do_alu(input logic [4:0] rd, input logic [31:0] res, input logic wb);
    check_eq("ready_alu", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; in_is_load = 1'b0; in_rd_addr = rd; in_wb_en = wb; in_result = res;
    in_funct3 = 3'($urandom); in_offset = 2'($urandom);
    if (wb && rd != 5'd0) sb_q.push_back('{1'b1, 1'b0, rd, res});
    m_retire++;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // dly = wait cycles without rvalid before the response cycle; dly >= TO means no response.
  task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                         input logic [31:0] w, input int dly, input logic wb);
    logic leg;
    leg = model_legal(f3, off);
    check_eq("ready_load", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; in_is_load = 1'b1; in_rd_addr = rd; in_wb_en = wb;
    in_funct3 = f3; in_offset = off; in_result = $urandom;
    if (!leg) sb_q.push_back('{1'b0, 1'b1, 5'd0, 32'd0});
    @(posedge clk); #1;
    in_valid = 1'b0; in_is_load = 1'b0;
    if (!leg) begin
      check_eq("ready_illegal", {63'd0, in_ready}, 64'd1);
      return;
    end
    if (dly >= TO) sb_q.push_back('{1'b0, 1'b1, 5'd0, 32'd0});
    for (int i = 0; i < dly && i < TO; i++) begin
      check_eq("ready_wait", {63'd0, in_ready}, 64'd0);
      dmem_rdata = $urandom;
      @(posedge clk); #1;
    end
    if (dly >= TO) begin
      check_eq("ready_timeout", {63'd0, in_ready}, 64'd1);
      return;
    end
    check_eq("ready_wait", {63'd0, in_ready}, 64'd0);
    dmem_rvalid = 1'b1; dmem_rdata = w;
    if (wb && rd != 5'd0) sb_q.push_back('{1'b1, 1'b0, rd, model_fmt(f3, off, w)});
    m_retire++;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0; dmem_rdata = $urandom;
    check_eq("ready_after_load", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] f3s [7];
    f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110};

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_write_en", {63'd0, write_en}, 64'd0);
    check_eq("rst_err", {63'd0, err}, 64'd0);
    check_eq("rst_rd_addr", {59'd0, rd_addr}, 64'd0);
    check_eq("rst_rd_data", {32'd0, rd_data}, 64'd0);
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
`ifdef WB_RETIRE_CNT_EN
    check_eq("rst_retire", retire_cnt, 64'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_alu(5'd5, 32'hDEADBEEF, 1'b1);
    do_alu(5'd0, 32'h00001234, 1'b1);
    do_alu(5'd9, 32'h0BADF00D, 1'b0);
    for (int i = 0; i < 8; i++) do_alu(5'($urandom), $urandom, 1'($urandom));

    do_load(5'd7, 3'b000, 2'd2, 32'h12F45678, 3, 1'b1);
    do_load(5'd7, 3'b100, 2'd2, 32'h12F45678, 3, 1'b1);
    do_load(5'd7, 3'b101, 2'd2, 32'h12F45678, 3, 1'b1);
    do_load(5'd8, 3'b001, 2'd0, 32'h0000A5C3, 0, 1'b1);
    do_load(5'd3, 3'b010, 2'd0, 32'h89ABCDEF, 1, 1'b1);
    do_load(5'd4, 3'b010, 2'd1, 32'h11111111, 0, 1'b1);
    do_load(5'd4, 3'b001, 2'd3, 32'h22222222, 0, 1'b1);
    do_load(5'd6, 3'b011, 2'd0, 32'h33333333, 0, 1'b1);
    do_load(5'd10, 3'b010, 2'd0, 32'h44444444, TO, 1'b1);
    do_load(5'd11, 3'b000, 2'd3, 32'h80FFFFFF, TO - 1, 1'b1);
    do_load(5'd0, 3'b010, 2'd0, 32'h55555555, 2, 1'b1);

    for (int i = 0; i < 12; i++) begin
      do_load(5'($urandom), f3s[$urandom_range(0, 6)], 2'($urandom), $urandom,
              int'($urandom_range(0, 4)), 1'($urandom));
      if (i % 3 == 0) do_alu(5'($urandom), $urandom, 1'b1);
    end

    // Reset while a load is pending, then a stray response in IDLE.
    in_valid = 1'b1; in_is_load = 1'b1; in_rd_addr = 5'd12; in_wb_en = 1'b1;
    in_funct3 = 3'b010; in_offset = 2'd0;
    @(posedge clk); #1;
    in_valid = 1'b0; in_is_load = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_retire = 64'd0;
    check_eq("ready_after_rst", {63'd0, in_ready}, 64'd1);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h66666666;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) do_alu(5'(i), 32'h1000 + 32'(i), 1'(i % 2));
    do_load(5'd2, 3'b010, 2'd2, 32'h77777777, 0, 1'b1);
    repeat (3) @(posedge clk); #1;
`ifdef WB_RETIRE_CNT_EN
    check_eq("retire_cnt", retire_cnt, m_retire);
`endif
    check_eq("queue_drained", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
